usrt_tx_serializer: RTL and testbench

//  Downstream stage of the TX parity generator. Accepts one framed word per handshake:
//  11 bits {start, data[7:0], parity, stop}, MSB = start.

---
 rtl/usrt_pkg.sv | 20 ++
 rtl/usrt_bit_timer.sv | 37 +++
 rtl/usrt_tx_serializer.sv | 114 +++++++++++
 tb/tb_usrt_tx_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame width, parity mode codes and TX FSM state encodings.
// No logic; constants and types only.
// Imported by the serializer top and its bit timer.
package usrt_pkg;

    // Frame layout {start, data[7:0], parity, stop}; MSB is the start bit.
    localparam int FRAME_W = 11;

    // Parity mode codes from the parity generator. 2'b11 is treated as "parity present".
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } tx_state_t;

endpackage

// File: rtl/usrt_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit and flags the Sclk rise point and bit end.
// Latency: ticks are combinational from the counter; the counter restarts the cycle after clear or bit end.
// Backpressure: none; it advances only while i_Enable is high.
// Ports: i_Clk, i_Rst (sync, active high), i_Clear (restart at 0), i_Enable (count),
//        o_Half_tick (last low-Sclk cycle of a bit), o_Bit_tick (last cycle of a bit).
module usrt_bit_timer
    import usrt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Half_tick,
    output logic o_Bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign o_Half_tick = i_Enable & (r_cnt == HALF_M1);
    assign o_Bit_tick  = i_Enable & (r_cnt == LAST);

    // The counter is cleared at every bit end, so it never wraps on its own.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clear || o_Bit_tick) begin
            r_cnt <= '0;
        end else if (i_Enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/usrt_tx_serializer.sv
// USRT TX serializer: shifts an accepted frame out MSB-first, one bit per CLKS_PER_BIT clocks, with Sclk.
// Latency: first bit on o_Txd the cycle after accept; o_Done pulses one cycle after the last bit period.
// Backpressure: o_Ready is high only in IDLE/DONE; i_Valid is ignored while shifting.
// Ports: i_Clk, i_Rst (sync, active high), i_Valid/o_Ready handshake, i_Frame, i_Parity (mode),
//        o_Txd serial data, o_Sclk serial clock (idle high, rises mid-bit), o_Busy, o_Done.
module usrt_tx_serializer
    import usrt_pkg::*;
#(
    parameter int   FRAME_W      = usrt_pkg::FRAME_W,
    parameter int   CLKS_PER_BIT = 4,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [FRAME_W-1:0] i_Frame,
    input  logic [1:0]         i_Parity,
    output logic               o_Txd,
    output logic               o_Sclk,
    output logic               o_Busy,
    output logic               o_Done
);

    localparam int BLW = $clog2(FRAME_W + 1);

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [FRAME_W-1:0] r_shreg;
    logic [BLW-1:0]     r_bits_left;
    logic               r_sclk;
    logic               w_accept;
    logic               w_shift;
    logic               w_half_tick;
    logic               w_bit_tick;
    logic               w_last_bit;

    assign w_shift    = (r_state == ST_SHIFT);
    assign w_accept   = i_Valid & o_Ready;
    assign w_last_bit = w_bit_tick & (r_bits_left == BLW'(1));

    // Ready is forced low while reset is held so nothing is accepted on the reset edge.
    assign o_Ready = ~i_Rst & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign o_Busy  = w_shift;
    assign o_Done  = (r_state == ST_DONE);
    assign o_Txd   = w_shift ? r_shreg[FRAME_W-1] : IDLE_LEVEL;
    assign o_Sclk  = r_sclk;

    usrt_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Clear     (w_accept),
        .i_Enable    (w_shift),
        .o_Half_tick (w_half_tick),
        .o_Bit_tick  (w_bit_tick)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Without parity the parity slot is dropped: stop moves up next to data and one bit fewer is sent.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_shreg     <= '1;
            r_bits_left <= '0;
        end else if (w_accept) begin
            if (i_Parity != PAR_NONE) begin
                r_shreg     <= i_Frame;
                r_bits_left <= BLW'(FRAME_W);
            end else begin
                r_shreg     <= {i_Frame[FRAME_W-1:2], i_Frame[0], 1'b1};
                r_bits_left <= BLW'(FRAME_W - 1);
            end
        end else if (w_shift && w_bit_tick) begin
            r_shreg     <= {r_shreg[FRAME_W-2:0], 1'b1};
            r_bits_left <= r_bits_left - BLW'(1);
        end
    end

    // Sclk is low for the first half of each bit; it stays high after the final bit and while idle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sclk <= 1'b1;
        end else if (w_accept) begin
            r_sclk <= 1'b0;
        end else if (w_shift) begin
            if (w_bit_tick) begin
                r_sclk <= w_last_bit;
            end else if (w_half_tick) begin
                r_sclk <= 1'b1;
            end
        end else begin
            r_sclk <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usrt_tx_serializer.sv
// Directed bench for usrt_tx_serializer with CLKS_PER_BIT=4.
// Cycle k = the clock period following the k-th rising edge after the accept edge.
// All outputs are sampled 1 time unit after the rising edge.
module tb_usrt_tx_serializer;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [10:0] i_Frame = '0;
    logic [1:0]  i_Parity = 2'b00;
    logic        o_Txd;
    logic        o_Sclk;
    logic        o_Busy;
    logic        o_Done;

    int n_tests = 0;
    int n_fail  = 0;

    usrt_tx_serializer #(
        .FRAME_W      (11),
        .CLKS_PER_BIT (4),
        .IDLE_LEVEL   (1'b1)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Valid  (i_Valid),
        .o_Ready  (o_Ready),
        .i_Frame  (i_Frame),
        .i_Parity (i_Parity),
        .o_Txd    (o_Txd),
        .o_Sclk   (o_Sclk),
        .o_Busy   (o_Busy),
        .o_Done   (o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    // Presents a frame, lets it be accepted, and checks every cycle of it plus the Done cycle.
    // exp_bits holds the expected line bits MSB-first in its low nbits bits.
    // hold: keep i_Valid high and switch i_Frame to nxt after accept (back-to-back).
    // inj: cycle at which a 7FF frame is waved at the busy serializer (0 = none).
    task automatic run_frame(input string tag, input logic [10:0] fr, input logic [1:0] par,
                             input logic [10:0] exp_bits, input int nbits,
                             input bit hold, input logic [10:0] nxt, input int inj);
        int   rises;
        logic prev_sclk;
        rises     = 0;
        prev_sclk = 1'b1;
        i_Frame   = fr;
        i_Parity  = par;
        i_Valid   = 1'b1;
        for (int k = 1; k <= nbits * 4; k++) begin
            step();
            if (k == 1) begin
                if (hold) i_Frame = nxt;
                else      i_Valid = 1'b0;
            end
            check({tag, " txd"},  32'(o_Txd),  32'(exp_bits[nbits - 1 - (k - 1) / 4]));
            check({tag, " sclk"}, 32'(o_Sclk), 32'(((k - 1) % 4) >= 2));
            check({tag, " busy"}, 32'(o_Busy), 32'd1);
            check({tag, " done"}, 32'(o_Done), 32'd0);
            if (!prev_sclk && o_Sclk) rises++;
            prev_sclk = o_Sclk;
            if (!hold && inj != 0 && k == inj) begin
                i_Valid = 1'b1;
                i_Frame = 11'h7FF;
            end
            if (!hold && inj != 0 && k == inj + 1) begin
                i_Valid = 1'b0;
                i_Frame = fr;
            end
        end
        step();
        check({tag, " sclk_rises"}, 32'(rises), 32'(nbits));
        check({tag, " done_pulse"}, 32'(o_Done), 32'd1);
        check({tag, " done_txd"},   32'(o_Txd),  32'd1);
        check({tag, " done_sclk"},  32'(o_Sclk), 32'd1);
        check({tag, " done_busy"},  32'(o_Busy), 32'd0);
        check({tag, " done_ready"}, 32'(o_Ready), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        step();
        check({tag, " idle_done"},  32'(o_Done),  32'd0);
        check({tag, " idle_ready"}, 32'(o_Ready), 32'd1);
        check({tag, " idle_busy"},  32'(o_Busy),  32'd0);
        check({tag, " idle_txd"},   32'(o_Txd),   32'd1);
    endtask

    initial begin
        logic [10:0] f1;
        logic [10:0] f2;
        int          dones;
        f1 = 11'b0_10100101_0_1;
        f2 = 11'b0_00110011_1_1;

        // Reset values
        step();
        step();
        check("rst ready", 32'(o_Ready), 32'd0);
        check("rst txd",   32'(o_Txd),   32'd1);
        check("rst sclk",  32'(o_Sclk),  32'd1);
        check("rst busy",  32'(o_Busy),  32'd0);
        check("rst done",  32'(o_Done),  32'd0);
        i_Rst = 1'b0;
        #1;
        check("post_rst ready", 32'(o_Ready), 32'd1);
        step();

        // 1: even parity, 11 bits, plus a 7FF frame offered while busy at cycle 10
        run_frame("s1", f1, 2'b01, 11'b0_10100101_0_1, 11, 1'b0, f1, 10);
        check_idle("s1");

        // 2: no parity, parity slot dropped -> 10 bits
        run_frame("s2", f1, 2'b00, 11'b0_0_10100101_1, 10, 1'b0, f1, 0);
        check_idle("s2");

        // 6: mode 11 behaves like parity present
        run_frame("s6", f1, 2'b11, 11'b0_10100101_0_1, 11, 1'b0, f1, 0);
        check_idle("s6");

        // 3: back-to-back with i_Valid held; second start bit follows the 1-cycle Done gap
        run_frame("s3a", f1, 2'b10, 11'b0_10100101_0_1, 11, 1'b1, f2, 0);
        run_frame("s3b", f2, 2'b10, 11'b0_00110011_1_1, 11, 1'b0, f2, 0);
        check_idle("s3");

        // 4: reset mid-frame at cycle 20
        i_Frame  = f1;
        i_Parity = 2'b01;
        i_Valid  = 1'b1;
        step();
        i_Valid = 1'b0;
        for (int k = 2; k <= 20; k++) step();
        check("s4 busy_before", 32'(o_Busy), 32'd1);
        i_Rst = 1'b1;
        step();
        check("s4 txd",   32'(o_Txd),   32'd1);
        check("s4 sclk",  32'(o_Sclk),  32'd1);
        check("s4 busy",  32'(o_Busy),  32'd0);
        check("s4 ready_in_rst", 32'(o_Ready), 32'd0);
        i_Rst = 1'b0;
        #1;
        check("s4 ready", 32'(o_Ready), 32'd1);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_Done) dones++;
        end
        check("s4 no_done", 32'(dones), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
